// File: rtl/blur_pkg.sv
// Shared constants, state encoding and pointer helper for the 5x5 blur
// line-buffer sequencer.
package blur_pkg;

  localparam int KERNEL    = 5;
  localparam int NUM_BUF   = KERNEL - 1;
  localparam int BUF_DEPTH = 1024;
  localparam int BUF_IDX_W = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef logic [1:0] buf_ptr_t;

  // Buffer pointers rotate through the four row buffers.
  function automatic buf_ptr_t mod4_inc(input buf_ptr_t p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/row_buffer_seq_if.sv
// Signal bundle between the pixel source / buffer bank / window mux and the
// row-buffer sequencer.
interface row_buffer_seq_if;
  import blur_pkg::*;

  // pix_valid is a pure strobe with no back-pressure: every strobe seen while
  // busy (or together with frame_start) is accepted that same cycle.
  logic                 frame_start;
  logic                 pix_valid;
  logic [NUM_BUF-1:0]   buf_wr_en;
  logic                 buf_rd_en;
  logic                 buf_line_rst;
  logic [1:0]           row_age_base;
  logic [BUF_IDX_W-1:0] col;
  logic [BUF_IDX_W-1:0] row;
  logic                 window_valid;
  logic                 busy;
  logic                 frame_done;
  state_t               state_dbg;

  modport master (
    output frame_start, pix_valid,
    input  buf_wr_en, buf_rd_en, buf_line_rst, row_age_base,
    input  col, row, window_valid, busy, frame_done, state_dbg
  );

  modport slave (
    input  frame_start, pix_valid,
    output buf_wr_en, buf_rd_en, buf_line_rst, row_age_base,
    output col, row, window_valid, busy, frame_done, state_dbg
  );

endinterface

// File: rtl/row_buffer_seq_pix_pos_counter.sv
// Column/row position of the accepted pixel stream, with end-of-line and
// end-of-frame strobes for the pixel being accepted this cycle.
module pix_pos_counter
  import blur_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [BUF_IDX_W-1:0] col,
  output logic [BUF_IDX_W-1:0] row,
  output logic                 eol,
  output logic                 eof
);

  localparam logic [BUF_IDX_W-1:0] COL_LAST = BUF_IDX_W'(IMG_WIDTH - 1);
  localparam logic [BUF_IDX_W-1:0] ROW_LAST = BUF_IDX_W'(IMG_HEIGHT - 1);

  // A clearing cycle accepts its pixel as (0,0), which is never a line end.
  assign eol = inc && !clear && (col == COL_LAST);
  assign eof = eol && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= inc ? BUF_IDX_W'(1) : '0;
      row <= '0;
    end else if (inc) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + BUF_IDX_W'(1);
      end else begin
        col <= col + BUF_IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/row_buffer_seq.sv
// Sequencer for the four-row line-buffer bank feeding the 5x5 blur window:
// rotates the written buffer, issues index resets/read enables, tracks row age.
module row_buffer_seq
  import blur_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int KERNEL     = blur_pkg::KERNEL,
  parameter int NUM_BUF    = blur_pkg::NUM_BUF
) (
  input  logic             clk,
  input  logic             reset,
  row_buffer_seq_if.slave  bus
);

  localparam logic [BUF_IDX_W-1:0] ROW_FILL_LAST = BUF_IDX_W'(KERNEL - 2);
  localparam logic [BUF_IDX_W-1:0] WIN_COL_MIN   = BUF_IDX_W'(KERNEL - 1);

  state_t               state;
  state_t               state_nxt;
  buf_ptr_t             wr_ptr;
  buf_ptr_t             wr_sel;
  buf_ptr_t             age_base;
  logic                 accept;
  logic                 eol;
  logic                 eof;
  logic                 line_rst_q;
  logic                 wv_nxt;
  logic                 wv_q;
  logic                 fd_nxt;
  logic                 fd_q;
  logic [BUF_IDX_W-1:0] col;
  logic [BUF_IDX_W-1:0] row;

  // A frame_start pixel is taken even from IDLE, where it becomes pixel (0,0).
  assign accept = bus.pix_valid && (state != IDLE || bus.frame_start) && !reset;

  pix_pos_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .clear (bus.frame_start),
    .inc   (accept),
    .col   (col),
    .row   (row),
    .eol   (eol),
    .eof   (eof)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.frame_start) begin
      state_nxt = FILL;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        FILL:    if (eol && row == ROW_FILL_LAST) state_nxt = RUN;
        RUN:     if (eof) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_sel           = bus.frame_start ? buf_ptr_t'(0) : wr_ptr;
    bus.busy         = (state != IDLE);
    bus.buf_wr_en    = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      bus.buf_wr_en[i] = accept && (wr_sel == buf_ptr_t'(i));
    end
    bus.buf_rd_en    = accept && !bus.frame_start && (state == RUN);
    bus.buf_line_rst = reset || bus.frame_start || line_rst_q;
    // Row >= KERNEL-1 is implied by RUN, so only the column needs testing.
    wv_nxt           = accept && !bus.frame_start && (state == RUN) && (col >= WIN_COL_MIN);
    fd_nxt           = eof;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      age_base   <= '0;
      line_rst_q <= 1'b0;
      wv_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      line_rst_q <= eol;
      wv_q       <= wv_nxt;
      fd_q       <= fd_nxt;
      if (bus.frame_start) begin
        wr_ptr   <= '0;
        age_base <= '0;
      end else if (eol) begin
        wr_ptr <= mod4_inc(wr_ptr);
        // Age tracking starts with the line that completes the fill.
        if (state == RUN || row == ROW_FILL_LAST) begin
          age_base <= mod4_inc(wr_ptr);
        end
      end
    end
  end

  assign bus.col          = col;
  assign bus.row          = row;
  assign bus.row_age_base = age_base;
  assign bus.window_valid = wv_q;
  assign bus.frame_done   = fd_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_row_buffer_seq.sv
// Bench for row_buffer_seq on an 8x6 image: directed vector table, directed
// frame sequences and randomized frames against a pixel-index reference model.
module tb_row_buffer_seq;
  import blur_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam int K = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  row_buffer_seq_if bus();

  row_buffer_seq #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame position as a linear pixel index.
  bit         m_active;
  int         m_p;
  int         m_rows_done;
  bit         m_lrst;
  logic [1:0] exp_q[$];

  int         wv_seen;
  int         fd_seen;
  logic [3:0] s_wr;
  logic       s_lrst;
  logic       s_busy;
  int         s_col;
  int         s_row;

  typedef struct {
    bit         r;
    bit         f;
    bit         v;
    logic [3:0] wr;
    bit         lrst;
    bit         busy;
    int         col;
    int         row;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the next one.
  task automatic cycle(input bit r, input bit f, input bit v);
    int         q;
    int         qr;
    int         qc;
    bit         acc;
    logic [3:0] e_wr;
    logic [1:0] e_reg;
    int         e_base;
    reset           = r;
    bus.frame_start = f;
    bus.pix_valid   = v;
    #3;
    q      = f ? 0 : m_p;
    qr     = q / W;
    qc     = q % W;
    acc    = v && (m_active || f) && !r;
    e_wr   = acc ? 4'(1 << (qr % 4)) : 4'd0;
    e_base = (m_rows_done >= 4) ? (m_rows_done % 4) : 0;
    chk("buf_wr_en",    32'(bus.buf_wr_en),    32'(e_wr));
    chk("buf_rd_en",    32'(bus.buf_rd_en),    32'(acc && !f && qr >= K - 1));
    chk("buf_line_rst", 32'(bus.buf_line_rst), 32'(r || f || m_lrst));
    chk("busy",         32'(bus.busy),         32'(m_active));
    chk("col",          32'(bus.col),          32'(m_p % W));
    chk("row",          32'(bus.row),          32'(m_p / W));
    chk("row_age_base", 32'(bus.row_age_base), 32'(e_base));
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: expected queue empty");
      e_reg = 2'b00;
    end else begin
      e_reg = exp_q.pop_front();
    end
    chk("window_valid", 32'(bus.window_valid), 32'(e_reg[1]));
    chk("frame_done",   32'(bus.frame_done),   32'(e_reg[0]));
    s_wr   = bus.buf_wr_en;
    s_lrst = bus.buf_line_rst;
    s_busy = bus.busy;
    s_col  = int'(bus.col);
    s_row  = int'(bus.row);
    if (bus.window_valid === 1'b1) wv_seen++;
    if (bus.frame_done === 1'b1) fd_seen++;
    @(posedge clk);
    #1;
    if (r) begin
      m_active    = 1'b0;
      m_p         = 0;
      m_rows_done = 0;
      m_lrst      = 1'b0;
      exp_q.delete();
      exp_q.push_back(2'b00);
    end else begin
      exp_q.push_back({acc && !f && qr >= K - 1 && qc >= K - 1, acc && !f && q == W * H - 1});
      m_lrst = acc && !f && qc == W - 1;
      if (f) begin
        m_active    = 1'b1;
        m_p         = v ? 1 : 0;
        m_rows_done = 0;
      end else if (acc) begin
        m_p++;
        if (qc == W - 1) m_rows_done++;
        if (m_p == W * H) begin
          m_active = 1'b0;
          m_p      = 0;
        end
      end
    end
  endtask

  // mode 0: back-to-back, 1: one idle cycle before each pixel, 2: random gaps
  task automatic feed(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic run_frame(input int mode);
    cycle(1'b0, 1'b1, 1'b1);
    feed(W * H - 1, mode);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    m_active        = 1'b0;
    m_p             = 0;
    m_rows_done     = 0;
    m_lrst          = 1'b0;
    wv_seen         = 0;
    fd_seen         = 0;
    exp_q.push_back(2'b00);

    //          r  f  v  wr       lrst busy col row
    tbl[0]  = '{1, 0, 1, 4'b0000, 1,   0,   0,  0};
    tbl[1]  = '{0, 0, 1, 4'b0000, 0,   0,   0,  0};
    tbl[2]  = '{0, 0, 1, 4'b0000, 0,   0,   0,  0};
    tbl[3]  = '{0, 1, 1, 4'b0001, 1,   0,   0,  0};
    tbl[4]  = '{0, 0, 1, 4'b0001, 0,   1,   1,  0};
    tbl[5]  = '{0, 0, 0, 4'b0000, 0,   1,   2,  0};
    tbl[6]  = '{0, 0, 1, 4'b0001, 0,   1,   2,  0};
    tbl[7]  = '{0, 0, 1, 4'b0001, 0,   1,   3,  0};
    tbl[8]  = '{0, 0, 1, 4'b0001, 0,   1,   4,  0};
    tbl[9]  = '{0, 0, 1, 4'b0001, 0,   1,   5,  0};
    tbl[10] = '{0, 0, 1, 4'b0001, 0,   1,   6,  0};
    tbl[11] = '{0, 0, 1, 4'b0001, 0,   1,   7,  0};
    tbl[12] = '{0, 0, 1, 4'b0010, 1,   1,   0,  1};
    tbl[13] = '{0, 0, 0, 4'b0000, 0,   1,   1,  1};
    tbl[14] = '{0, 1, 0, 4'b0000, 1,   1,   1,  1};
    tbl[15] = '{0, 0, 0, 4'b0000, 0,   1,   0,  0};
    tbl[16] = '{1, 0, 1, 4'b0000, 1,   1,   0,  0};
    tbl[17] = '{0, 0, 1, 4'b0000, 0,   0,   0,  0};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].r, tbl[i].f, tbl[i].v);
      chk($sformatf("tbl%0d_wr", i),   32'(s_wr),   32'(tbl[i].wr));
      chk($sformatf("tbl%0d_lrst", i), 32'(s_lrst), 32'(tbl[i].lrst));
      chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_col", i),  32'(s_col),  32'(tbl[i].col));
      chk($sformatf("tbl%0d_row", i),  32'(s_row),  32'(tbl[i].row));
    end

    // Continuous frame.
    wv_seen = 0; fd_seen = 0;
    run_frame(0);
    chk("cont_windows", 32'(wv_seen), 32'd8);
    chk("cont_frame_done", 32'(fd_seen), 32'd1);

    // pix_valid every other cycle.
    wv_seen = 0; fd_seen = 0;
    run_frame(1);
    chk("toggle_windows", 32'(wv_seen), 32'd8);
    chk("toggle_frame_done", 32'(fd_seen), 32'd1);

    // Abort at pixel (3,2), then a full frame.
    wv_seen = 0; fd_seen = 0;
    cycle(1'b0, 1'b1, 1'b1);
    feed(2 * W + 3 - 1, 0);
    run_frame(0);
    chk("abort_windows", 32'(wv_seen), 32'd8);
    chk("abort_frame_done", 32'(fd_seen), 32'd1);

    // Reset during row 4, then a normal frame.
    wv_seen = 0; fd_seen = 0;
    cycle(1'b0, 1'b1, 1'b1);
    feed(4 * W + 3 - 1, 0);
    cycle(1'b1, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b1);
    chk("rst_mid_frame_done", 32'(fd_seen), 32'd0);
    run_frame(0);
    chk("post_rst_windows", 32'(wv_seen), 32'd8);
    chk("post_rst_frame_done", 32'(fd_seen), 32'd1);

    // Randomized frames with gaps, aborts, resets and idle noise.
    for (int k = 0; k < 12; k++) begin
      int cut;
      cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W * H - 2)) : W * H - 1;
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      feed(cut, 2);
      if (cut < W * H - 1 && $urandom_range(0, 1) == 1) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 4)) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    repeat (4) cycle(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
